// File: rtl/nibble_serial_sub16.sv
// Digit-serial subtractor: D = A - B - Bin, one DIGIT-wide slice per clock, LSB digit first.
// Start is accepted whenever busy is low; results are held until the next completion.
module nibble_serial_sub16 #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             a_msb_q, b_msb_q, brw_q;
    logic             busy_q, done_q, bout_q, ovf_q, zero_q;
    logic [WIDTH-1:0] d_q;

    logic [DIGIT:0]   slice_d;
    logic             brw_d;
    logic [WIDTH-1:0] res_d;
    logic             ovf_d, zero_d;

    // Operands shift right one digit per cycle so the slice always sees the low digit;
    // the result fills from the top, so after NDIG shifts it is in place.
    always_comb begin
        slice_d = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw_q};
        brw_d   = slice_d[DIGIT];
        res_d   = {slice_d[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
        ovf_d   = (a_msb_q ^ b_msb_q) & (res_d[WIDTH-1] ^ a_msb_q);
        zero_d  = (res_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            brw_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
                        brw_q   <= bin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> DIGIT;
                    b_q   <= b_q >> DIGIT;
                    brw_q <= brw_d;
                    res_q <= res_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        d_q     <= res_d;
                        bout_q  <= brw_d;
                        ovf_q   <= ovf_d;
                        zero_q  <= zero_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_nibble_serial_sub16.sv
// Bench for nibble_serial_sub16: directed cases, mid-run start pokes, async reset and
// randomized operands, checked by a negedge monitor against a queue of expected results.
module tb_nibble_serial_sub16;
    localparam int W  = 16;
    localparam int EW = 32 + W + 3;   // {due_cycle, d, bout, ovf, zero}

    logic         clk = 1'b0;
    logic         rst_n, start, bin;
    logic [W-1:0] a, b;
    logic         busy, done, bout, ovf, zero;
    logic [W-1:0] d;

    always #5 clk = ~clk;

    nibble_serial_sub16 #(.WIDTH(W), .DIGIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .d(d), .bout(bout), .ovf(ovf), .zero(zero)
    );

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [EW-1:0] exp_q[$];
    logic [W-1:0]  held_d = '0;
    logic          held_bout = 1'b0, held_ovf = 1'b0, held_zero = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for borrow, signed range for overflow.
    function automatic logic [EW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                            input logic mbin, input int due);
        int           ud, sd;
        logic [W-1:0] dd;
        logic         bo, ov, zz;
        ud = int'(ma) - int'(mb) - int'(mbin);
        sd = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        dd = ud[W-1:0];
        bo = (ud < 0);
        ov = (sd < -32768) || (sd > 32767);
        zz = (dd == '0);
        return {32'(due), dd, bo, ov, zz};
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return W'($urandom);
        endcase
    endfunction

    // Monitor: busy, done timing and held outputs every cycle.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic          due_now, busy_exp;
        cyc++;
        due_now  = (exp_q.size() > 0) && (exp_q[0][EW-1:W+3] == 32'(cyc));
        busy_exp = (exp_q.size() > 0) && !due_now;
        chk("busy", 32'(busy), 32'(busy_exp));
        chk("done", 32'(done), 32'(due_now));
        if (due_now) begin
            e = exp_q.pop_front();
            held_d    = e[W+2:3];
            held_bout = e[2];
            held_ovf  = e[1];
            held_zero = e[0];
        end
        chk("d", 32'(d), 32'(held_d));
        chk("bout", 32'(bout), 32'(held_bout));
        chk("ovf", 32'(ovf), 32'(held_ovf));
        chk("zero", 32'(zero), 32'(held_zero));
    end

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            chk("issue_wait_timeout", 32'(busy), 32'd0);
            return;
        end
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        bin   = tbin;
        @(posedge clk);
        exp_q.push_back(model(ta, tb_v, tbin, cyc + 5));
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        bin   = 1'($urandom);
    endtask

    // Raise start with junk operands while an operation is running; it must be ignored.
    task automatic poke(input int skip);
        repeat (skip) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = W'($urandom);
        b     = W'($urandom);
        bin   = 1'($urandom);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        int g;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_d", 32'(d), 32'd0);
        rst_n = 1'b1;

        issue(16'h1234, 16'h0234, 1'b0);
        issue(16'h0000, 16'h0001, 1'b0);
        issue(16'h1000, 16'h0001, 1'b0);
        issue(16'h8000, 16'h0001, 1'b0);
        issue(16'h7FFF, 16'hFFFF, 1'b0);
        issue(16'h00FF, 16'h00FE, 1'b1);

        issue(16'h4321, 16'h1111, 1'b0);
        poke(1);
        issue(16'h0100, 16'h0101, 1'b1);

        issue(16'hFFFF, 16'h0001, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        held_d    = '0;
        held_bout = 1'b0;
        held_ovf  = 1'b0;
        held_zero = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_d", 32'(d), 32'd0);
        chk("async_rst_bout", 32'(bout), 32'd0);
        chk("async_rst_ovf", 32'(ovf), 32'd0);
        chk("async_rst_zero", 32'(zero), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(16'h0005, 16'h0003, 1'b0);

        for (int n = 0; n < 160; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(pick(), pick(), 1'($urandom));
            if ($urandom_range(0, 3) == 0) poke($urandom_range(0, 2));
        end

        g = 0;
        while (exp_q.size() > 0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() > 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_serial_sub16.md
Name: nibble_serial_sub16

Overview:
- Multi-cycle 16-bit subtractor: computes D = A − B − Bin and the borrow-out, one 4-bit digit per clock, LSB digit first.
- Complements the combinational ripple-carry adder datapath. Reuses a single 4-bit subtract slice over 4 cycles instead of 4 parallel slices.
- Used by the arithmetic lab datapath wherever area matters more than latency.
- Start/busy/done handshake; results are held until the next operation.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per clock. Latency = WIDTH/DIGIT cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  minuend; sampled with start
- b  input  WIDTH  subtrahend; sampled with start
- bin  input  1  borrow-in; sampled with start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, result valid
- d  output  WIDTH  difference
- bout  output  1  borrow-out (1 = unsigned a < b + bin)
- ovf  output  1  two's-complement overflow
- zero  output  1  d == 0

Behaviour:
- Reset (rst_n=0, async, any time including mid-operation):
  - state=IDLE, digit counter=0.
  - busy=0, done=0, d=0, bout=0, ovf=0, zero=0.
  - The operation in flight is discarded and no done is generated.
- FSM has two states, IDLE and RUN.
- IDLE: when start=1 at edge E0:
  - latch a, b, bin into internal operand registers; borrow register <= bin; counter <= 0.
  - state <= RUN; busy <= 1.
- RUN: at each edge Ek (k=1..WIDTH/DIGIT), digit i=k−1:
  - {brw, diff_i} = a_i − b_i − brw, where a_i = a[DIGIT*i +: DIGIT].
  - diff_i is written into the internal result register; counter increments.
- Final edge E(WIDTH/DIGIT), i.e. E4 at default parameters:
  - d, bout, ovf, zero update together.
  - done <= 1 for exactly one cycle; busy <= 0; state <= IDLE.
- Latency: done is high in the cycle following E4 = 4 cycles after the start-sampling edge.
- Throughput: one operation per 4 cycles. start=1 during the done cycle is accepted (busy=0), so back-to-back operations need no gap cycle.
- start=1 while busy=1 is ignored: no queuing, no corruption of the operation in flight.
- Input changes after E0 have no effect until the next accepted start.
- d/bout/ovf/zero hold the previous result for the whole RUN phase and until the next completion. No partial results are ever visible.
- ovf = (a[WIDTH−1] ^ b[WIDTH−1]) & (d[WIDTH−1] ^ a[WIDTH−1]), using latched operands; correct for either value of bin.
- zero = (d == 0), computed from the final result at the final edge.
- All arithmetic is modulo 2^WIDTH. The borrow ripples across digit boundaries through the borrow register only.

Test Plan:
1. a=0x1234, b=0x0234, bin=0, start pulse → busy high 4 cycles; done pulse 4 cycles after start; d=0x1000, bout=0, ovf=0, zero=0.
2. a=0x0000, b=0x0001, bin=0 → d=0xFFFF, bout=1, ovf=0. Then a=0x1000, b=0x0001 → d=0x0FFF; borrow crosses 3 digits.
3. a=0x8000, b=0x0001, bin=0 → d=0x7FFF, ovf=1, bout=0. Then a=0x7FFF, b=0xFFFF → d=0x8000, ovf=1, bout=1.
4. a=0x00FF, b=0x00FE, bin=1 → d=0x0000, zero=1, bout=0, ovf=0.
5. Start an operation; assert start with new operands at RUN cycle 2 → ignored, first result unchanged. Then assert start in the done cycle → accepted; second done exactly 4 cycles later with the correct result.
6. Start a=0xFFFF, b=0x0001, pull rst_n low asynchronously at RUN cycle 2 → all outputs 0 immediately, no done. Release reset, run a=0x0005, b=0x0003 → d=0x0002 after 4 cycles.
